lw_hash_arbiter: RTL and testbench

//  Shares one lw_hmac core between N_REQ requesters (e.g. CPU mailbox, DMA key-wrap).

---
 rtl/lw_hash_arbiter.sv | 234 +++++++++++++++++++++++
 tb/tb_lw_hash_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lw_hash_arbiter.sv
// Round-robin arbiter sharing one lw_hmac core between N_REQ requesters.
// Grants whole operations, muxes the owner onto the core and routes results back to the owner only.
module lw_hash_arbiter #(
    parameter int unsigned N_REQ     = 2,
    parameter int unsigned WORD_SIZE = 64,
    parameter int unsigned OP_W      = 4,
    parameter int unsigned WDOG_MAX  = 1023
) (
    input  logic                         clk_i,
    input  logic                         aresetn_i,
    input  logic [N_REQ-1:0]             req_i,
    output logic [N_REQ-1:0]             gnt_o,
    input  logic [N_REQ-1:0]             rq_start_i,
    input  logic [N_REQ-1:0]             rq_abort_i,
    input  logic [N_REQ-1:0]             rq_last_i,
    input  logic [N_REQ-1:0]             rq_data_valid_i,
    input  logic [N_REQ*WORD_SIZE-1:0]   rq_data_i,
    input  logic [N_REQ*OP_W-1:0]        rq_opcode_i,
    input  logic [N_REQ*WORD_SIZE-1:0]   rq_key_i,
    input  logic [N_REQ-1:0]             rq_key_valid_i,
    output logic [N_REQ-1:0]             rq_ready_o,
    output logic [N_REQ-1:0]             rq_key_ready_o,
    output logic [N_REQ-1:0]             rq_done_o,
    output logic [N_REQ-1:0]             rq_timeout_o,
    output logic [8*WORD_SIZE-1:0]       hash_o,
    output logic                         core_start_o,
    output logic                         core_abort_o,
    output logic                         core_last_o,
    output logic                         core_data_valid_o,
    output logic [WORD_SIZE-1:0]         core_data_o,
    output logic [OP_W-1:0]              core_opcode_o,
    output logic [WORD_SIZE-1:0]         core_key_o,
    output logic                         core_key_valid_o,
    input  logic                         core_ready_i,
    input  logic                         core_key_ready_i,
    input  logic                         core_core_ready_i,
    input  logic                         core_done_i,
    input  logic [8*WORD_SIZE-1:0]       core_hash_i
);

    localparam int unsigned IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned WD_W   = (WDOG_MAX > 0) ? $clog2(WDOG_MAX + 1) : 1;
    localparam int unsigned HASH_W = 8 * WORD_SIZE;

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_BUSY, S_RELEASE} state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [IDX_W-1:0]    rr_q, rr_d;
    logic [N_REQ-1:0]    gnt_q, gnt_d;
    logic [N_REQ-1:0]    done_q, done_d;
    logic [N_REQ-1:0]    tout_q, tout_d;
    logic [HASH_W-1:0]   hash_q, hash_d;
    logic [OP_W-1:0]     opcode_q, opcode_d;
    logic [WD_W-1:0]     wdog_q, wdog_d;

    logic                own_req, own_start, own_abort, own_last, own_dv, own_kv;
    logic [WORD_SIZE-1:0] own_data, own_key;
    logic [OP_W-1:0]     own_op;
    logic                active, owner_act, wd_idle, wd_expire, rel;
    logic                pick_found;
    logic [IDX_W-1:0]    pick_idx;

    // Select the current owner's request lanes
    always_comb begin
        own_req   = 1'b0;
        own_start = 1'b0;
        own_abort = 1'b0;
        own_last  = 1'b0;
        own_dv    = 1'b0;
        own_kv    = 1'b0;
        own_data  = '0;
        own_key   = '0;
        own_op    = '0;
        for (int n = 0; n < int'(N_REQ); n++) begin
            if (IDX_W'(n) == owner_q) begin
                own_req   = req_i[n];
                own_start = rq_start_i[n];
                own_abort = rq_abort_i[n];
                own_last  = rq_last_i[n];
                own_dv    = rq_data_valid_i[n];
                own_kv    = rq_key_valid_i[n];
                own_data  = rq_data_i[n*WORD_SIZE +: WORD_SIZE];
                own_key   = rq_key_i[n*WORD_SIZE +: WORD_SIZE];
                own_op    = rq_opcode_i[n*OP_W +: OP_W];
            end
        end
    end

    // First requester at or after the round-robin pointer
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            for (int n = 0; n < int'(N_REQ); n++) begin
                if (!pick_found && req_i[n] && (((int'(rr_q) + i) % int'(N_REQ)) == n)) begin
                    pick_found = 1'b1;
                    pick_idx   = IDX_W'(n);
                end
            end
        end
    end

    // Watchdog only counts while the core waits on an idle owner; a done in BUSY beats expiry
    assign active    = (state_q == S_GRANT) || (state_q == S_BUSY);
    assign owner_act = own_start || own_dv || own_kv;
    assign wd_idle   = active && !owner_act && (core_ready_i || core_key_ready_i);
    assign wd_expire = (WDOG_MAX != 0) && wd_idle && (wdog_q == WD_W'(WDOG_MAX))
                       && !((state_q == S_BUSY) && core_done_i);

    // Core-side mux: only the owner reaches the core
    always_comb begin
        core_start_o      = 1'b0;
        core_abort_o      = 1'b0;
        core_last_o       = 1'b0;
        core_data_valid_o = 1'b0;
        core_data_o       = '0;
        core_opcode_o     = '0;
        core_key_o        = '0;
        core_key_valid_o  = 1'b0;
        if (active) begin
            core_start_o      = (state_q == S_GRANT) && own_start;
            core_abort_o      = own_abort || wd_expire;
            core_last_o       = own_last;
            core_data_valid_o = own_dv;
            core_data_o       = own_data;
            core_opcode_o     = (state_q == S_BUSY) ? opcode_q : own_op;
            core_key_o        = own_key;
            core_key_valid_o  = own_kv;
        end
    end

    assign rq_ready_o     = gnt_q & {N_REQ{core_ready_i}};
    assign rq_key_ready_o = gnt_q & {N_REQ{core_key_ready_i}};
    assign gnt_o          = gnt_q;
    assign rq_done_o      = done_q;
    assign rq_timeout_o   = tout_q;
    assign hash_o         = hash_q;

    // Next-state and registered-output logic
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_d     = rr_q;
        gnt_d    = gnt_q;
        done_d   = '0;
        tout_d   = '0;
        hash_d   = hash_q;
        opcode_d = opcode_q;
        wdog_d   = wdog_q;
        rel      = 1'b0;

        if (active) begin
            if (owner_act) begin
                wdog_d = '0;
            end else if (wd_idle && (wdog_q != WD_W'(WDOG_MAX))) begin
                wdog_d = wdog_q + 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                wdog_d = '0;
                if (pick_found && core_core_ready_i) begin
                    owner_d         = pick_idx;
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                    state_d         = S_GRANT;
                end
            end
            S_GRANT: begin
                if (own_abort) begin
                    rel = 1'b1;
                end else if (wd_expire) begin
                    rel             = 1'b1;
                    tout_d[owner_q] = 1'b1;
                end else if (own_start && own_dv) begin
                    state_d  = S_BUSY;
                    opcode_d = own_op;
                end else if (!own_req) begin
                    rel = 1'b1;
                end
            end
            S_BUSY: begin
                if (own_abort) begin
                    rel = 1'b1;
                end else if (core_done_i) begin
                    rel             = 1'b1;
                    done_d[owner_q] = 1'b1;
                    hash_d          = core_hash_i;
                end else if (wd_expire) begin
                    rel             = 1'b1;
                    tout_d[owner_q] = 1'b1;
                end
            end
            S_RELEASE: begin
                state_d = S_IDLE;
                rr_d    = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (rel) begin
            state_d = S_RELEASE;
            gnt_d   = '0;
            wdog_d  = '0;
        end
    end

    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            state_q  <= S_IDLE;
            owner_q  <= '0;
            rr_q     <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            tout_q   <= '0;
            hash_q   <= '0;
            opcode_q <= '0;
            wdog_q   <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_q     <= rr_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            tout_q   <= tout_d;
            hash_q   <= hash_d;
            opcode_q <= opcode_d;
            wdog_q   <= wdog_d;
        end
    end

endmodule

// File: tb/tb_lw_hash_arbiter.sv
// Self-checking bench for lw_hash_arbiter with a behavioural stand-in for the lw_hmac core.
// Expected (owner, hash) pairs are queued at start and popped when rq_done_o fires.
module tb_lw_hash_arbiter;

    localparam int unsigned N    = 2;
    localparam int unsigned WS   = 64;
    localparam int unsigned OPW  = 4;
    localparam int unsigned WDOG = 16;
    localparam int unsigned HW   = 8 * WS;

    logic              clk_i = 1'b0;
    logic              aresetn_i;
    logic [N-1:0]      req_i, gnt_o;
    logic [N-1:0]      rq_start_i, rq_abort_i, rq_last_i, rq_data_valid_i, rq_key_valid_i;
    logic [N*WS-1:0]   rq_data_i, rq_key_i;
    logic [N*OPW-1:0]  rq_opcode_i;
    logic [N-1:0]      rq_ready_o, rq_key_ready_o, rq_done_o, rq_timeout_o;
    logic [HW-1:0]     hash_o;
    logic              core_start_o, core_abort_o, core_last_o, core_data_valid_o, core_key_valid_o;
    logic [WS-1:0]     core_data_o, core_key_o;
    logic [OPW-1:0]    core_opcode_o;
    logic              core_ready_i, core_key_ready_i, core_core_ready_i, core_done_i;
    logic [HW-1:0]     core_hash_i;

    typedef struct {
        logic [N-1:0]  gnt;
        logic [HW-1:0] hash;
    } exp_t;

    exp_t          sb[$];
    exp_t          e;
    int            checks = 0;
    int            errors = 0;
    logic [HW-1:0] last_hash;
    logic [31:0]   abc_w [8] = '{32'hBA7816BF, 32'h8F01CFEA, 32'h414140DE, 32'h5DAE2223,
                                 32'hB00361A3, 32'h96177A9C, 32'hB410FF61, 32'hF20015AD};

    lw_hash_arbiter #(.N_REQ(N), .WORD_SIZE(WS), .OP_W(OPW), .WDOG_MAX(WDOG)) dut (
        .clk_i(clk_i), .aresetn_i(aresetn_i), .req_i(req_i), .gnt_o(gnt_o),
        .rq_start_i(rq_start_i), .rq_abort_i(rq_abort_i), .rq_last_i(rq_last_i),
        .rq_data_valid_i(rq_data_valid_i), .rq_data_i(rq_data_i), .rq_opcode_i(rq_opcode_i),
        .rq_key_i(rq_key_i), .rq_key_valid_i(rq_key_valid_i), .rq_ready_o(rq_ready_o),
        .rq_key_ready_o(rq_key_ready_o), .rq_done_o(rq_done_o), .rq_timeout_o(rq_timeout_o),
        .hash_o(hash_o), .core_start_o(core_start_o), .core_abort_o(core_abort_o),
        .core_last_o(core_last_o), .core_data_valid_o(core_data_valid_o), .core_data_o(core_data_o),
        .core_opcode_o(core_opcode_o), .core_key_o(core_key_o), .core_key_valid_o(core_key_valid_o),
        .core_ready_i(core_ready_i), .core_key_ready_i(core_key_ready_i),
        .core_core_ready_i(core_core_ready_i), .core_done_i(core_done_i), .core_hash_i(core_hash_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [HW-1:0] mk_hash(input logic [31:0] seed);
        logic [HW-1:0] h;
        for (int w = 0; w < 8; w++) h[w*WS +: WS] = {seed, 32'(w) ^ 32'hC3A5_0F1E};
        return h;
    endfunction

    task automatic neg();
        @(negedge clk_i);
    endtask

    task automatic clear_strobes();
        rq_start_i = '0; rq_abort_i = '0; rq_last_i = '0; rq_data_valid_i = '0; rq_key_valid_i = '0;
    endtask

    task automatic drive_start(input int n, input logic [WS-1:0] d, input logic [OPW-1:0] op);
        rq_start_i[n] = 1'b1; rq_data_valid_i[n] = 1'b1; rq_last_i[n] = 1'b1;
        rq_data_i[n*WS +: WS] = d;
        rq_opcode_i[n*OPW +: OPW] = op;
    endtask

    task automatic wait_done(output bit got);
        got = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            neg();
            core_done_i = 1'b0;
            if (|rq_done_o) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        aresetn_i = 1'b0; req_i = '0; clear_strobes();
        rq_data_i = '0; rq_key_i = '0; rq_opcode_i = '0;
        core_ready_i = 1'b1; core_key_ready_i = 1'b0; core_core_ready_i = 1'b1;
        core_done_i = 1'b0; core_hash_i = '0;
        repeat (2) neg();
        checks++; if (gnt_o !== '0) begin errors++; $display("FAIL reset_gnt got %b want 00", gnt_o); end
        checks++; if (rq_done_o !== '0 || rq_timeout_o !== '0) begin errors++; $display("FAIL reset_pulses done %b tout %b want 0", rq_done_o, rq_timeout_o); end
        checks++; if (hash_o !== '0) begin errors++; $display("FAIL reset_hash got %h want 0", hash_o[63:0]); end
        checks++; if ({core_start_o, core_abort_o, core_data_valid_o, core_key_valid_o} !== 4'b0 || rq_ready_o !== '0) begin
            errors++; $display("FAIL reset_core_outs got %b rdy %b want 0", {core_start_o, core_abort_o, core_data_valid_o, core_key_valid_o}, rq_ready_o); end
        aresetn_i = 1'b1;
        repeat (2) neg();
        checks++; if (gnt_o !== '0) begin errors++; $display("FAIL idle_no_req_gnt got %b want 00", gnt_o); end
    endtask

    task automatic test_rr();
        bit got;
        logic [HW-1:0] h;
        req_i = 2'b11;
        neg();
        checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL rr_first_gnt got %b want 01", gnt_o); end
        h = mk_hash(32'h11);
        drive_start(0, 64'h1111, 4'h0); sb.push_back('{2'b01, h});
        neg(); clear_strobes(); core_ready_i = 1'b0;
        neg(); core_done_i = 1'b1; core_hash_i = h;
        wait_done(got);
        e = sb.pop_front();
        checks++; if (!got || rq_done_o !== e.gnt || hash_o !== e.hash) begin
            errors++; $display("FAIL rr_done0 got done %b hash %h want %b %h", rq_done_o, hash_o[63:0], e.gnt, e.hash[63:0]); end
        last_hash = e.hash;
        core_ready_i = 1'b1;
        repeat (2) neg();
        checks++; if (gnt_o !== 2'b10) begin errors++; $display("FAIL rr_second_gnt got %b want 10", gnt_o); end
        h = mk_hash(32'h22);
        drive_start(1, 64'h2222, 4'h0); sb.push_back('{2'b10, h});
        neg(); clear_strobes(); core_ready_i = 1'b0; req_i = '0;
        neg(); core_done_i = 1'b1; core_hash_i = h;
        wait_done(got);
        e = sb.pop_front();
        checks++; if (!got || rq_done_o !== e.gnt || hash_o !== e.hash) begin
            errors++; $display("FAIL rr_done1 got done %b hash %h want %b %h", rq_done_o, hash_o[63:0], e.gnt, e.hash[63:0]); end
        last_hash = e.hash;
        core_ready_i = 1'b1;
        repeat (2) neg();
    endtask

    task automatic test_single();
        bit got;
        logic [HW-1:0] h;
        for (int w = 0; w < 8; w++) h[w*WS +: WS] = 64'(abc_w[w]);
        req_i = 2'b01;
        neg();
        checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL single_gnt got %b want 01", gnt_o); end
        drive_start(0, 64'h6162_6380_0000_0000, 4'h0);
        #1;
        checks++; if (core_start_o !== 1'b1 || core_data_valid_o !== 1'b1 || core_last_o !== 1'b1 || core_data_o !== 64'h6162_6380_0000_0000) begin
            errors++; $display("FAIL single_fwd got st %b dv %b last %b data %h want 1 1 1 6162638000000000", core_start_o, core_data_valid_o, core_last_o, core_data_o); end
        sb.push_back('{2'b01, h});
        neg(); clear_strobes(); core_ready_i = 1'b0; rq_opcode_i[3:0] = 4'h5;
        #1;
        checks++; if (core_opcode_o !== 4'h0 || core_start_o !== 1'b0) begin
            errors++; $display("FAIL single_op_latch got op %h st %b want 0 0", core_opcode_o, core_start_o); end
        neg(); core_done_i = 1'b1; core_hash_i = h;
        wait_done(got);
        e = sb.pop_front();
        checks++; if (!got || rq_done_o !== e.gnt || hash_o !== e.hash || gnt_o !== 2'b00) begin
            errors++; $display("FAIL single_done got done %b gnt %b hash %h want %b 00 %h", rq_done_o, gnt_o, hash_o[63:0], e.gnt, e.hash[63:0]); end
        last_hash = e.hash;
        req_i = '0; rq_opcode_i = '0; core_ready_i = 1'b1;
        neg();
        checks++; if (rq_done_o !== '0 || hash_o !== last_hash) begin
            errors++; $display("FAIL single_pulse_hold got done %b hash %h want 00 %h", rq_done_o, hash_o[63:0], last_hash[63:0]); end
        neg();
    endtask

    task automatic test_nonowner();
        bit got;
        logic [HW-1:0] h;
        req_i = 2'b01;
        neg();
        checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL nonowner_gnt got %b want 01", gnt_o); end
        req_i = 2'b11; rq_data_valid_i[1] = 1'b1; rq_key_valid_i[1] = 1'b1;
        rq_data_i[WS +: WS] = 64'hDEAD_BEEF; core_key_ready_i = 1'b1;
        #1;
        checks++; if (core_data_valid_o !== 1'b0 || core_key_valid_o !== 1'b0 || rq_ready_o !== 2'b01 || rq_key_ready_o !== 2'b01) begin
            errors++; $display("FAIL nonowner_mask got dv %b kv %b rdy %b krdy %b want 0 0 01 01", core_data_valid_o, core_key_valid_o, rq_ready_o, rq_key_ready_o); end
        h = mk_hash(32'h33);
        drive_start(0, 64'h0A0B_0C0D, 4'h0); sb.push_back('{2'b01, h});
        #1;
        checks++; if (core_data_o !== 64'h0A0B_0C0D || core_data_valid_o !== 1'b1) begin
            errors++; $display("FAIL nonowner_owner_data got %h dv %b want 0a0b0c0d 1", core_data_o, core_data_valid_o); end
        neg(); clear_strobes(); rq_data_valid_i[1] = 1'b1; req_i = 2'b10;
        core_ready_i = 1'b0; core_key_ready_i = 1'b0;
        #1;
        checks++; if (core_data_valid_o !== 1'b0) begin errors++; $display("FAIL nonowner_busy_dv got %b want 0", core_data_valid_o); end
        neg(); core_done_i = 1'b1; core_hash_i = h;
        wait_done(got);
        req_i = '0; clear_strobes();
        e = sb.pop_front();
        checks++; if (!got || rq_done_o !== e.gnt || hash_o !== e.hash) begin
            errors++; $display("FAIL nonowner_done got done %b hash %h want %b %h", rq_done_o, hash_o[63:0], e.gnt, e.hash[63:0]); end
        last_hash = e.hash;
        core_ready_i = 1'b1;
        repeat (2) neg();
    endtask

    task automatic test_watchdog();
        int cnt;
        req_i = 2'b01;
        neg();
        checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL wdog_gnt got %b want 01", gnt_o); end
        drive_start(0, 64'h4B45_59, 4'h1); core_ready_i = 1'b0; core_key_ready_i = 1'b1;
        neg(); clear_strobes();
        #1;
        cnt = 0;
        while (!core_abort_o && cnt < 40) begin
            neg();
            cnt++;
        end
        checks++; if (cnt != int'(WDOG)) begin errors++; $display("FAIL wdog_cycles got %0d want %0d", cnt, WDOG); end
        req_i = 2'b10;
        neg(); core_key_ready_i = 1'b0;
        checks++; if (rq_timeout_o !== 2'b01 || gnt_o !== 2'b00 || rq_done_o !== 2'b00 || core_abort_o !== 1'b0) begin
            errors++; $display("FAIL wdog_release got tout %b gnt %b done %b abort %b want 01 00 00 0", rq_timeout_o, gnt_o, rq_done_o, core_abort_o); end
        repeat (2) neg();
        checks++; if (gnt_o !== 2'b10 || rq_timeout_o !== 2'b00) begin
            errors++; $display("FAIL wdog_next_gnt got %b tout %b want 10 00", gnt_o, rq_timeout_o); end
        rq_abort_i[1] = 1'b1;
        #1;
        checks++; if (core_abort_o !== 1'b1) begin errors++; $display("FAIL wdog_owner_abort got %b want 1", core_abort_o); end
        neg(); clear_strobes(); req_i = '0; core_ready_i = 1'b1;
        repeat (2) neg();
    endtask

    task automatic test_abort_done();
        bit bad;
        req_i = 2'b01;
        neg();
        checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL abdone_gnt got %b want 01", gnt_o); end
        drive_start(0, 64'h5555, 4'h0);
        neg(); clear_strobes(); core_ready_i = 1'b0;
        neg(); core_done_i = 1'b1; core_hash_i = mk_hash(32'h99); rq_abort_i[0] = 1'b1;
        #1;
        checks++; if (core_abort_o !== 1'b1) begin errors++; $display("FAIL abdone_fwd got %b want 1", core_abort_o); end
        neg(); core_done_i = 1'b0; clear_strobes(); req_i = '0;
        checks++; if (rq_done_o !== 2'b00 || hash_o !== last_hash || gnt_o !== 2'b00) begin
            errors++; $display("FAIL abdone_no_done got done %b gnt %b hash %h want 00 00 %h", rq_done_o, gnt_o, hash_o[63:0], last_hash[63:0]); end
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            neg();
            if (rq_done_o !== 2'b00) bad = 1'b1;
        end
        checks++; if (bad) begin errors++; $display("FAIL abdone_late_done got a done pulse want none"); end
        core_ready_i = 1'b1;
    endtask

    task automatic test_reset_mid();
        req_i = 2'b10;
        neg();
        checks++; if (gnt_o !== 2'b10) begin errors++; $display("FAIL rstmid_gnt got %b want 10", gnt_o); end
        drive_start(1, 64'h6666, 4'h0);
        neg(); clear_strobes(); core_ready_i = 1'b0;
        neg(); aresetn_i = 1'b0;
        #1;
        checks++; if (gnt_o !== 2'b00 || hash_o !== '0 || rq_done_o !== 2'b00) begin
            errors++; $display("FAIL rstmid_async got gnt %b done %b hash %h want 00 00 0", gnt_o, rq_done_o, hash_o[63:0]); end
        neg(); aresetn_i = 1'b1; req_i = 2'b11; core_ready_i = 1'b1;
        neg();
        checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL rstmid_rr got %b want 01", gnt_o); end
        rq_abort_i[0] = 1'b1;
        neg(); clear_strobes(); req_i = '0;
        repeat (2) neg();
    endtask

    initial begin
        test_reset();
        test_rr();
        test_single();
        test_nonowner();
        test_watchdog();
        test_abort_done();
        test_reset_mid();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_empty got %0d want 0", sb.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got no finish want finish");
        $fatal(1, "timeout");
    end

endmodule
